fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 8-register pipelined core; sits directly upstream of the decode stage.
- Owns the PC and drives a request/ready instruction-memory port.
- Consumes the hazard controls stallPC, stallID, flush and the redirect target from EX.
- Produces instrID, pcPlus1ID and validID for decode.

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/if_id_reg.sv | 59 +++++
 rtl/fetch_stage.sv | 152 +++++++++++++++
 tb/tb_fetch_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the hazard logic that drives it.
package fetch_stage_pkg;

    // Default datapath widths of the 8-register core.
    localparam int unsigned DEFAULT_PC_W    = 16;
    localparam int unsigned DEFAULT_INSTR_W = 16;

    // Fetch FSM encoding.
    typedef enum logic [1:0] {
        StFetch = 2'b00,  // idle or issuing a new request
        StWait  = 2'b01,  // request outstanding, result wanted
        StDrop  = 2'b10   // request outstanding, result squashed by a redirect
    } fetchState_t;

    // Redirect kinds resolved in EX; 2'b00 means no redirect this cycle.
    typedef enum logic [1:0] {
        JNone   = 2'b00,
        JJump   = 2'b01,
        JBranch = 2'b10,
        JReg    = 2'b11
    } jType_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register plus a one-entry hold register that parks an
// instruction returned by memory while decode is stalled.
module if_id_reg #(
    parameter int unsigned PC_W    = 16,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,         // IF/ID <= fetched instruction
    input  logic               loadHold,     // IF/ID <= hold register
    input  logic               bubble,       // IF/ID becomes a bubble
    input  logic               holdWrite,    // hold register <= fetched instruction
    input  logic               holdClear,    // hold register emptied
    input  logic [INSTR_W-1:0] fetchData,
    input  logic [PC_W-1:0]    fetchPcPlus1,
    output logic [INSTR_W-1:0] instrID,
    output logic [PC_W-1:0]    pcPlus1ID,
    output logic               validID,
    output logic               holdValid
);

    logic [INSTR_W-1:0] holdInstr;
    logic [PC_W-1:0]    holdPcPlus1;

    // IF/ID register: hold-register unload wins over a fresh load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instrID   <= '0;
            pcPlus1ID <= '0;
            validID   <= 1'b0;
        end else if (loadHold) begin
            instrID   <= holdInstr;
            pcPlus1ID <= holdPcPlus1;
            validID   <= 1'b1;
        end else if (load) begin
            instrID   <= fetchData;
            pcPlus1ID <= fetchPcPlus1;
            validID   <= 1'b1;
        end else if (bubble) begin
            validID   <= 1'b0;
        end
    end

    // One-entry hold register for data that arrives during a decode stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdInstr   <= '0;
            holdPcPlus1 <= '0;
            holdValid   <= 1'b0;
        end else if (holdWrite) begin
            holdInstr   <= fetchData;
            holdPcPlus1 <= fetchPcPlus1;
            holdValid   <= 1'b1;
        end else if (holdClear) begin
            holdValid   <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the request/ready instruction
// memory port and feeds the IF/ID register. Priority is stallID > flush > normal.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned  PC_W     = DEFAULT_PC_W,
    parameter int unsigned  INSTR_W  = DEFAULT_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallPC,
    input  logic               stallID,
    input  logic               flush,
    input  logic [PC_W-1:0]    jTarget,
    output logic               imemReq,
    output logic [PC_W-1:0]    imemAddr,
    input  logic               imemReady,
    input  logic [INSTR_W-1:0] imemData,
    output logic [INSTR_W-1:0] instrID,
    output logic [PC_W-1:0]    pcPlus1ID,
    output logic               validID,
    output logic               fetchBusy
);

    fetchState_t     stateQ, stateD;
    logic [PC_W-1:0] pcQ, pcD;
    logic [PC_W-1:0] redirectQ, redirectD;
    logic [PC_W-1:0] pcPlus1;
    logic            req;
    logic            load, loadHold, bubble, holdWrite, holdClear;
    logic            holdValid;

    // PC+1 wraps naturally at 2^PC_W.
    assign pcPlus1 = pcQ + PC_W'(1);

    // State, PC and pending redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= StFetch;
            pcQ       <= RESET_PC;
            redirectQ <= RESET_PC;
        end else begin
            stateQ    <= stateD;
            pcQ       <= pcD;
            redirectQ <= redirectD;
        end
    end

    // Next-state, PC update and IF/ID control decode.
    always_comb begin
        stateD    = stateQ;
        pcD       = pcQ;
        redirectD = redirectQ;
        req       = 1'b0;
        load      = 1'b0;
        loadHold  = 1'b0;
        bubble    = 1'b0;
        holdWrite = 1'b0;
        holdClear = 1'b0;
        unique case (stateQ)
            StFetch: begin
                req = !stallPC && !stallID && !flush && !holdValid;
                if (stallID) begin
                    // Decode stalled: everything holds, flush is ignored.
                end else if (flush) begin
                    pcD       = jTarget;
                    bubble    = 1'b1;
                    holdClear = 1'b1;  // a parked instruction is squashed too
                end else if (holdValid) begin
                    loadHold  = 1'b1;
                    holdClear = 1'b1;
                end else if (req && imemReady) begin
                    load = 1'b1;
                    pcD  = pcPlus1;
                end else if (req) begin
                    bubble = 1'b1;
                    stateD = StWait;
                end else begin
                    // PC stalled alone: decode must not see the instruction twice.
                    bubble = 1'b1;
                end
            end
            StWait: begin
                req = 1'b1;
                if (stallID) begin
                    if (imemReady) begin
                        holdWrite = 1'b1;
                        pcD       = pcPlus1;
                        stateD    = StFetch;
                    end
                end else if (flush) begin
                    bubble = 1'b1;
                    if (imemReady) begin
                        pcD    = jTarget;
                        stateD = StFetch;
                    end else begin
                        redirectD = jTarget;
                        stateD    = StDrop;
                    end
                end else if (imemReady) begin
                    load   = 1'b1;
                    pcD    = pcPlus1;
                    stateD = StFetch;
                end else begin
                    bubble = 1'b1;
                end
            end
            StDrop: begin
                req = 1'b1;
                if (!stallID) begin
                    bubble = 1'b1;
                end
                // Latest redirect target wins while the stale request drains.
                if (flush && !stallID) begin
                    redirectD = jTarget;
                end
                if (imemReady) begin
                    pcD    = (flush && !stallID) ? jTarget : redirectQ;
                    stateD = StFetch;
                end
            end
            default: begin
                stateD = StFetch;
            end
        endcase
    end

    assign imemReq   = req && !rst;
    assign imemAddr  = pcQ;
    assign fetchBusy = (stateQ != StFetch);

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) uIfId (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .loadHold     (loadHold),
        .bubble       (bubble),
        .holdWrite    (holdWrite),
        .holdClear    (holdClear),
        .fetchData    (imemData),
        .fetchPcPlus1 (pcPlus1),
        .instrID      (instrID),
        .pcPlus1ID    (pcPlus1ID),
        .validID      (validID),
        .holdValid    (holdValid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the expected fetch order is queued as
// requests are allowed to complete and checked as decode consumes IF/ID.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallPC, stallID, flush, imemReady;
    logic [15:0] jTarget;
    logic        imemReq, validID, fetchBusy;
    logic [15:0] imemAddr, imemData, instrID, pcPlus1ID;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] expQ[$];
    logic [15:0] expPc;
    logic [15:0] monPc, monPc1;

    always #5 clk = ~clk;

    function automatic logic [15:0] instrOf(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Zero-latency memory model; imemReady is driven by the stimulus.
    assign imemData = instrOf(imemAddr);

    fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .stallPC   (stallPC),
        .stallID   (stallID),
        .flush     (flush),
        .jTarget   (jTarget),
        .imemReq   (imemReq),
        .imemAddr  (imemAddr),
        .imemReady (imemReady),
        .imemData  (imemData),
        .instrID   (instrID),
        .pcPlus1ID (pcPlus1ID),
        .validID   (validID),
        .fetchBusy (fetchBusy)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Free-running fetch of n sequential instructions starting at expPc.
    task automatic fetchRun(input int n);
        stallPC   = 1'b0;
        stallID   = 1'b0;
        flush     = 1'b0;
        imemReady = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            checkVal("fetchAddr", imemAddr, expPc);
            checkVal("fetchReq", imemReq, 1);
            expQ.push_back(expPc);
            step();
            checkVal("fetchValid", validID, 1);
            expPc = expPc + 16'd1;
        end
    endtask

    // Decode consumes IF/ID whenever it is valid and not stalled.
    always @(negedge clk) begin
        if (!rst && validID && !stallID) begin
            checkVal("deliveryQueued", (expQ.size() > 0) ? 1 : 0, 1);
            if (expQ.size() > 0) begin
                monPc  = expQ.pop_front();
                monPc1 = monPc + 16'd1;
                checkVal("deliveredInstr", instrID, instrOf(monPc));
                checkVal("deliveredPcPlus1", pcPlus1ID, monPc1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stallPC = 1'b0; stallID = 1'b0; flush = 1'b0;
        jTarget = 16'h0; imemReady = 1'b1; expPc = 16'h0;
        #12;
        checkVal("rstReq", imemReq, 0);
        checkVal("rstValid", validID, 0);
        checkVal("rstInstr", instrID, 0);
        checkVal("rstPcPlus1", pcPlus1ID, 0);
        checkVal("rstAddr", imemAddr, 0);
        checkVal("rstBusy", fetchBusy, 0);
        rst = 1'b0;

        // Back-to-back fetches with single-cycle memory.
        fetchRun(5);

        // Memory not ready for two cycles at pc=5.
        imemReady = 1'b0;
        #1;
        checkVal("waitAddr0", imemAddr, 16'h5);
        checkVal("waitBusy0", fetchBusy, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            checkVal("waitBusy", fetchBusy, 1);
            checkVal("waitValid", validID, 0);
            checkVal("waitAddr", imemAddr, 16'h5);
            checkVal("waitReq", imemReq, 1);
        end
        imemReady = 1'b1;
        expQ.push_back(16'h5);
        step();
        checkVal("waitDoneBusy", fetchBusy, 0);
        checkVal("waitDoneValid", validID, 1);
        checkVal("waitDonePcPlus1", pcPlus1ID, 16'h6);
        expPc = 16'h6;
        fetchRun(2);

        // Full stall at pc=8 for three cycles.
        stallPC = 1'b1; stallID = 1'b1;
        #1;
        checkVal("stallReq0", imemReq, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkVal("stallAddr", imemAddr, 16'h8);
            checkVal("stallValid", validID, 1);
            checkVal("stallPcPlus1", pcPlus1ID, 16'h8);
            checkVal("stallInstr", instrID, instrOf(16'h7));
            checkVal("stallReq", imemReq, 0);
        end
        fetchRun(1);

        // Flush during WAIT at pc=9; a second flush in DROP retargets.
        imemReady = 1'b0;
        step();
        checkVal("dropWaitBusy", fetchBusy, 1);
        checkVal("dropWaitAddr", imemAddr, 16'h9);
        flush = 1'b1; jTarget = 16'h30;
        step();
        checkVal("dropBusy", fetchBusy, 1);
        checkVal("dropAddrHeld", imemAddr, 16'h9);
        checkVal("dropValid", validID, 0);
        checkVal("dropReq", imemReq, 1);
        jTarget = 16'h20;
        step();
        checkVal("dropBusy2", fetchBusy, 1);
        checkVal("dropAddrHeld2", imemAddr, 16'h9);
        flush = 1'b0; imemReady = 1'b1;
        step();
        checkVal("dropDoneBusy", fetchBusy, 0);
        checkVal("dropDoneAddr", imemAddr, 16'h20);
        checkVal("dropDoneValid", validID, 0);
        expPc = 16'h20;
        fetchRun(1);

        // Flush in FETCH: ignored under stallID, taken otherwise.
        flush = 1'b1; stallID = 1'b1; jTarget = 16'h40;
        #1;
        checkVal("flushStallReq", imemReq, 0);
        step();
        checkVal("flushStallAddr", imemAddr, 16'h21);
        checkVal("flushStallValid", validID, 1);
        checkVal("flushStallPcPlus1", pcPlus1ID, 16'h21);
        stallID = 1'b0;
        step();
        checkVal("flushValid", validID, 0);
        checkVal("flushAddr", imemAddr, 16'h40);
        checkVal("flushBusy", fetchBusy, 0);
        expPc = 16'h40;
        fetchRun(2);

        // Data returns in WAIT while decode is stalled: parked, delivered once.
        imemReady = 1'b0;
        step();
        checkVal("holdWaitBusy", fetchBusy, 1);
        stallID = 1'b1; imemReady = 1'b1;
        expQ.push_back(16'h42);
        step();
        checkVal("holdBusy", fetchBusy, 0);
        checkVal("holdAddr", imemAddr, 16'h43);
        checkVal("holdValidID", validID, 0);
        checkVal("holdReqStalled", imemReq, 0);
        step();
        checkVal("holdValidID2", validID, 0);
        stallID = 1'b0;
        #1;
        checkVal("holdReqUnload", imemReq, 0);
        step();
        checkVal("holdOutValid", validID, 1);
        checkVal("holdOutPcPlus1", pcPlus1ID, 16'h43);
        checkVal("holdOutInstr", instrID, instrOf(16'h42));
        checkVal("holdOutAddr", imemAddr, 16'h43);
        expPc = 16'h43;
        fetchRun(1);

        // PC wrap at 0xFFFF.
        flush = 1'b1; jTarget = 16'hFFFF;
        step();
        expPc = 16'hFFFF;
        fetchRun(2);
        checkVal("wrapAddr", imemAddr, 16'h1);

        // Asynchronous reset while in DROP.
        imemReady = 1'b0;
        step();
        flush = 1'b1; jTarget = 16'h77;
        step();
        flush = 1'b0;
        checkVal("preRstBusy", fetchBusy, 1);
        #2;
        rst = 1'b1;
        #1;
        checkVal("asyncRstBusy", fetchBusy, 0);
        checkVal("asyncRstAddr", imemAddr, 16'h0);
        checkVal("asyncRstReq", imemReq, 0);
        checkVal("asyncRstValid", validID, 0);
        step();
        rst = 1'b0;
        expPc = 16'h0;
        fetchRun(2);

        // Let the last delivery drain, then confirm nothing is left over.
        imemReady = 1'b0;
        step();
        step();
        checkVal("drain", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
